capture_readout: RTL and testbench

- Read side of the logic analyzer sample buffer. The write/trigger path fills a circular capture RAM and asserts stopped.
- Once stopped rises, this block latches the write pointer and walks the RAM from oldest to newest sample.
- Samples go out on a valid/ready stream toward the host link (UART framer).
- Signals completion so host control logic can re-arm the scope.

---
 rtl/capture_readout.sv | 113 +++++++++++
 tb/tb_capture_readout.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_readout.sv
// Read side of the logic analyzer capture buffer: once the writer stops, walk the
// circular RAM from the oldest to the newest sample and stream it out on valid/ready.
module capture_readout #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stopped,
   input  logic [ADDR_WIDTH-1:0] wr_ptr,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_last,
   input  logic                  i_ready,
   output logic                  o_busy,
   output logic                  o_done
);

   // state   | meaning
   // IDLE    | waiting for stopped; latches wr_ptr as the oldest sample address
   // READ    | one-cycle RAM read strobe at rd_addr
   // WAIT    | RAM data arrives; captured into o_data, o_valid raised
   // PRESENT | holding the sample until the downstream handshake
   // DONE    | whole buffer sent; only reset leaves
   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      PRESENT,
      DONE
   } state_t;

   localparam logic [ADDR_WIDTH:0] LAST_CNT = {1'b0, {ADDR_WIDTH{1'b1}}};

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [ADDR_WIDTH:0]   count;
   logic                  handshake;

   assign handshake   = o_valid & i_ready;
   assign mem_rd_en   = (state == READ);
   assign mem_rd_addr = rd_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (stopped) state_nxt = READ;
         READ:    state_nxt = WAIT;
         WAIT:    state_nxt = PRESENT;
         PRESENT: begin
            if (handshake) state_nxt = o_last ? DONE : READ;
         end
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_addr <= '0;
         count   <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_last  <= 1'b0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (stopped) begin
                  rd_addr <= wr_ptr;
                  count   <= '0;
                  o_busy  <= 1'b1;
               end
            end
            WAIT: begin
               o_data  <= mem_rd_data;
               o_valid <= 1'b1;
               o_last  <= (count == LAST_CNT);
            end
            PRESENT: begin
               if (handshake) begin
                  o_valid <= 1'b0;
                  o_last  <= 1'b0;
                  if (o_last) begin
                     o_busy <= 1'b0;
                     o_done <= 1'b1;
                  end else begin
                     // rd_addr wraps modulo the RAM depth on its own
                     rd_addr <= rd_addr + ADDR_WIDTH'(1);
                     count   <= count + (ADDR_WIDTH + 1)'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_capture_readout.sv
// Bench for capture_readout with an 8-deep RAM model preloaded mem[i]=0x10+i;
// expected samples are queued at dump start and popped on each handshake.
module tb_capture_readout;

   localparam int DW = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          stopped = 1'b0;
   logic [AW-1:0] wr_ptr = '0;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data = '0;
   logic          o_valid;
   logic [DW-1:0] o_data;
   logic          o_last;
   logic          i_ready = 1'b0;
   logic          o_busy;
   logic          o_done;

   logic [DW-1:0] mem [8];
   logic [8:0]    exp_q [$];
   int            total = 0;
   int            bad = 0;

   capture_readout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .stopped     (stopped),
      .wr_ptr      (wr_ptr),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .o_valid     (o_valid),
      .o_data      (o_data),
      .o_last      (o_last),
      .i_ready     (i_ready),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic push_exp(input int wp);
      logic [8:0] v;
      for (int k = 0; k < 8; k++) begin
         v = {(k == 7), 8'(16 + ((wp + k) % 8))};
         exp_q.push_back(v);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b1;
      stopped = 1'b0;
      i_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // mode 0: always ready; mode 1: random ready with a 20-cycle low hold,
   // and stopped dropped mid-dump
   task automatic consume(input int mode, input int max_hs, input int budget, output int hs);
      logic [DW-1:0] prev_d;
      logic          prev_l;
      logic          prev_stall;
      logic          r;
      logic [8:0]    e;
      hs = 0;
      prev_stall = 1'b0;
      prev_d = '0;
      prev_l = 1'b0;
      for (int c = 0; c < budget && hs < max_hs && exp_q.size() > 0; c++) begin
         @(negedge clk);
         if (prev_stall) begin
            total++;
            if (o_valid !== 1'b1 || o_data !== prev_d || o_last !== prev_l) begin
               bad++;
               $display("FAIL stall_hold: got valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                        o_valid, o_data, o_last, prev_d, prev_l);
            end
         end
         if (mode == 1 && c == 5) stopped = 1'b0;
         if (mode == 0) r = 1'b1;
         else if (c >= 10 && c < 30) r = 1'b0;
         else r = 1'($urandom_range(0, 1));
         i_ready = r;
         if (o_valid === 1'b1) begin
            total++;
            if (o_busy !== 1'b1) begin
               bad++;
               $display("FAIL busy_during_dump: got %b want 1", o_busy);
            end
            if (r) begin
               e = exp_q.pop_front();
               total++;
               if ({o_last, o_data} !== e) begin
                  bad++;
                  $display("FAIL sample: got last=%b data=%h want last=%b data=%h",
                           o_last, o_data, e[8], e[7:0]);
               end
               hs++;
            end
         end
         prev_stall = (o_valid === 1'b1) && !r;
         prev_d = o_data;
         prev_l = o_last;
      end
      total++;
      if (hs != max_hs) begin
         bad++;
         $display("FAIL handshake_count: got %0d want %0d", hs, max_hs);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      stopped = 1'b1;
      wr_ptr = 3'd4;
      repeat (3) @(negedge clk);
      total++;
      if ({mem_rd_en, mem_rd_addr, o_valid, o_data, o_last, o_busy, o_done} !== '0) begin
         bad++;
         $display("FAIL reset_values: got rd_en=%b addr=%h valid=%b data=%h last=%b busy=%b done=%b want all 0",
                  mem_rd_en, mem_rd_addr, o_valid, o_data, o_last, o_busy, o_done);
      end
      stopped = 1'b0;
   endtask

   task automatic test_basic();
      int hs;
      do_reset();
      exp_q.delete();
      push_exp(5);
      wr_ptr = 3'd5;
      stopped = 1'b1;
      consume(0, 8, 200, hs);
      @(negedge clk);
      total++;
      if (o_done !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
         bad++;
         $display("FAIL basic_done: got done=%b busy=%b valid=%b want 1 0 0", o_done, o_busy, o_valid);
      end
   endtask

   task automatic test_latency();
      int hs;
      logic [8:0] e;
      do_reset();
      exp_q.delete();
      repeat (3) @(negedge clk);
      total++;
      if (mem_rd_en !== 1'b0 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
         bad++;
         $display("FAIL idle_quiet: got rd_en=%b busy=%b valid=%b want 0 0 0", mem_rd_en, o_busy, o_valid);
      end
      push_exp(5);
      wr_ptr = 3'd5;
      stopped = 1'b1;
      i_ready = 1'b1;
      for (int off = 1; off <= 9; off++) begin
         @(negedge clk);
         total++;
         if (mem_rd_en !== (off % 3 == 1) || o_valid !== (off % 3 == 0)) begin
            bad++;
            $display("FAIL latency_cycle%0d: got rd_en=%b valid=%b want rd_en=%b valid=%b",
                     off, mem_rd_en, o_valid, (off % 3 == 1), (off % 3 == 0));
         end
         if (off == 1) begin
            total++;
            if (mem_rd_addr !== 3'd5 || o_busy !== 1'b1) begin
               bad++;
               $display("FAIL first_read: got addr=%h busy=%b want addr=5 busy=1", mem_rd_addr, o_busy);
            end
         end
         if (o_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({o_last, o_data} !== e) begin
               bad++;
               $display("FAIL latency_sample: got last=%b data=%h want last=%b data=%h",
                        o_last, o_data, e[8], e[7:0]);
            end
         end
      end
      consume(0, 5, 200, hs);
      @(negedge clk);
      total++;
      if (o_done !== 1'b1) begin
         bad++;
         $display("FAIL latency_done: got %b want 1", o_done);
      end
   endtask

   task automatic test_backpressure();
      int hs;
      do_reset();
      exp_q.delete();
      push_exp(3);
      wr_ptr = 3'd3;
      stopped = 1'b1;
      consume(1, 8, 600, hs);
      @(negedge clk);
      total++;
      if (o_done !== 1'b1 || o_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_done: got done=%b valid=%b want 1 0", o_done, o_valid);
      end
   endtask

   task automatic test_boundaries();
      int hs;
      int wps [2] = '{0, 7};
      foreach (wps[i]) begin
         do_reset();
         exp_q.delete();
         push_exp(wps[i]);
         wr_ptr = 3'(wps[i]);
         stopped = 1'b1;
         consume(0, 8, 200, hs);
         @(negedge clk);
         total++;
         if (o_done !== 1'b1 || o_valid !== 1'b0) begin
            bad++;
            $display("FAIL boundary_done_wp%0d: got done=%b valid=%b want 1 0", wps[i], o_done, o_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      int hs;
      do_reset();
      exp_q.delete();
      push_exp(5);
      wr_ptr = 3'd5;
      stopped = 1'b1;
      consume(0, 3, 200, hs);
      @(negedge clk);
      reset = 1'b1;
      wr_ptr = 3'd2;
      @(negedge clk);
      total++;
      if ({mem_rd_en, mem_rd_addr, o_valid, o_data, o_last, o_busy, o_done} !== '0) begin
         bad++;
         $display("FAIL reset_mid: got rd_en=%b addr=%h valid=%b data=%h last=%b busy=%b done=%b want all 0",
                  mem_rd_en, mem_rd_addr, o_valid, o_data, o_last, o_busy, o_done);
      end
      exp_q.delete();
      push_exp(2);
      reset = 1'b0;
      consume(0, 8, 200, hs);
      @(negedge clk);
      total++;
      if (o_done !== 1'b1) begin
         bad++;
         $display("FAIL restart_done: got %b want 1", o_done);
      end
   endtask

   task automatic test_done_hold();
      int errs = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         stopped = 1'($urandom_range(0, 1));
         wr_ptr = 3'($urandom_range(0, 7));
         i_ready = 1'($urandom_range(0, 1));
         if (mem_rd_en !== 1'b0 || o_valid !== 1'b0 || o_done !== 1'b1 || o_busy !== 1'b0) errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL done_hold: got %0d bad cycles (rd_en=%b valid=%b done=%b) want 0",
                  errs, mem_rd_en, o_valid, o_done);
      end
      stopped = 1'b0;
      do_reset();
      total++;
      if (o_done !== 1'b0) begin
         bad++;
         $display("FAIL done_cleared: got %b want 0", o_done);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 8'(16 + i);
      test_reset();
      test_basic();
      test_latency();
      test_backpressure();
      test_boundaries();
      test_reset_mid();
      test_done_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
